// File: rtl/pong_game_2p.sv
// Two-player pong: paddles, ball, scores and serve/play/pause/over control,
// plus the per-pixel colour mux driven from the VGA scan position.
module pong_game_2p #(
  parameter int          X_MAX        = 639,
  parameter int          Y_MAX        = 479,
  parameter int          PAD_H        = 72,
  parameter int          PAD_W        = 4,
  parameter int          PADL_X       = 32,
  parameter int          PADR_X       = 604,
  parameter int          PAD_V        = 3,
  parameter int          BALL_SIZE    = 8,
  parameter int          BALL_V       = 2,
  parameter int          SCORE_W      = 4,
  parameter int          WIN_SCORE    = 7,
  parameter int          PAUSE_FRAMES = 60,
  parameter logic [11:0] PAD_RGB      = 12'hAAA,
  parameter logic [11:0] BALL_RGB     = 12'hFFF,
  parameter logic [11:0] LINE_RGB     = 12'h777,
  parameter logic [11:0] BG_RGB       = 12'h111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_l,
  input  logic               down_l,
  input  logic               up_r,
  input  logic               down_r,
  input  logic               serve,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [11:0]        rgb,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_FRAMES - 1);

  localparam logic [9:0] TICK_Y   = 10'(Y_MAX + 2);
  localparam logic [9:0] PAD_MAX  = 10'(Y_MAX + 1 - PAD_H);
  localparam logic [9:0] PAD_INIT = 10'((Y_MAX + 1 - PAD_H) / 2);
  localparam logic [9:0] PAD_HM1  = 10'(PAD_H - 1);
  localparam logic [9:0] STEP_PAD = 10'(PAD_V);
  localparam logic [9:0] STEP_BAL = 10'(BALL_V);
  localparam logic [9:0] BALL_X0  = 10'((X_MAX + 1 - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0  = 10'((Y_MAX + 1 - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_M1  = 10'(BALL_SIZE - 1);
  localparam logic [9:0] PL_X0    = 10'(PADL_X);
  localparam logic [9:0] PL_X1    = 10'(PADL_X + PAD_W - 1);
  localparam logic [9:0] PL_HIT1  = 10'(PADL_X + PAD_W - 1 + BALL_V);
  localparam logic [9:0] PR_X0    = 10'(PADR_X);
  localparam logic [9:0] PR_X1    = 10'(PADR_X + PAD_W - 1);
  localparam logic [9:0] PR_HIT0  = 10'(PADR_X - BALL_V);
  localparam logic [9:0] WALL_B   = 10'(Y_MAX - BALL_V);
  localparam logic [9:0] WALL_R   = 10'(X_MAX - BALL_V);
  localparam logic [9:0] LINE_X0  = 10'((X_MAX + 1) / 2 - 1);
  localparam logic [9:0] LINE_X1  = 10'((X_MAX + 1) / 2);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  logic [9:0]         pad_l, pad_r, ball_x, ball_y;
  logic               dir_x, dir_y;   // dir_x 1 = right, dir_y 1 = down
  logic [CNT_W-1:0]   pause_cnt;

  logic       tick;
  logic [9:0] ball_r, ball_b;
  logic       ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic       dir_x_nx, dir_y_nx;

  assign tick   = (y == TICK_Y) && (x == 10'd0);
  assign ball_r = ball_x + BALL_M1;
  assign ball_b = ball_y + BALL_M1;

  function automatic logic [9:0] pad_next(input logic [9:0] top, input logic up_b,
                                          input logic down_b);
    logic [9:0] nxt;
    nxt = top;
    if (!up_b && down_b)
      nxt = (top >= STEP_PAD) ? top - STEP_PAD : 10'd0;
    else if (!down_b && up_b)
      nxt = (top + STEP_PAD >= PAD_MAX) ? PAD_MAX : top + STEP_PAD;
    return nxt;
  endfunction

  // Collision decisions use the current position; the ball then moves along the new direction.
  always_comb begin
    dir_y_nx = dir_y;
    if (ball_y <= STEP_BAL && !dir_y)
      dir_y_nx = 1'b1;
    else if (ball_b >= WALL_B && dir_y)
      dir_y_nx = 1'b0;

    ovl_l  = (ball_y <= pad_l + PAD_HM1) && (ball_b >= pad_l);
    ovl_r  = (ball_y <= pad_r + PAD_HM1) && (ball_b >= pad_r);
    hit_l  = !dir_x && (ball_x >= PL_X0) && (ball_x <= PL_HIT1) && ovl_l;
    hit_r  = dir_x && (ball_r >= PR_HIT0) && (ball_r <= PR_X1) && ovl_r;

    dir_x_nx = dir_x;
    if (hit_l)
      dir_x_nx = 1'b1;
    else if (hit_r)
      dir_x_nx = 1'b0;

    miss_l = !hit_l && !hit_r && (ball_x < STEP_BAL);
    miss_r = !hit_l && !hit_r && !miss_l && (ball_r > WALL_R);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_SERVE;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
      pad_l     <= PAD_INIT;
      pad_r     <= PAD_INIT;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      pause_cnt <= '0;
    end else if (tick) begin
      if (state_q != S_OVER) begin
        pad_l <= pad_next(pad_l, up_l, down_l);
        pad_r <= pad_next(pad_r, up_r, down_r);
      end
      case (state_q)
        S_SERVE: begin
          if (!serve)
            state_q <= S_PLAY;
        end
        S_PLAY: begin
          dir_y <= dir_y_nx;
          // On a miss dir_x is aimed at the losing player for the next serve.
          if (miss_l) begin
            score_r   <= score_r + 1'b1;
            dir_x     <= 1'b0;
            pause_cnt <= PAUSE_LOAD;
            state_q   <= S_PAUSE;
          end else if (miss_r) begin
            score_l   <= score_l + 1'b1;
            dir_x     <= 1'b1;
            pause_cnt <= PAUSE_LOAD;
            state_q   <= S_PAUSE;
          end else begin
            dir_x  <= dir_x_nx;
            ball_x <= dir_x_nx ? ball_x + STEP_BAL : ball_x - STEP_BAL;
            ball_y <= dir_y_nx ? ball_y + STEP_BAL : ball_y - STEP_BAL;
          end
        end
        S_PAUSE: begin
          if (pause_cnt != '0) begin
            pause_cnt <= pause_cnt - 1'b1;
          end else if (score_l == WIN || score_r == WIN) begin
            state_q   <= S_OVER;
            game_over <= 1'b1;
          end else begin
            state_q <= S_SERVE;
            ball_x  <= BALL_X0;
            ball_y  <= BALL_Y0;
            dir_y   <= 1'b1;
          end
        end
        S_OVER: begin
          if (!serve) begin
            state_q   <= S_SERVE;
            game_over <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
          end
        end
        default: state_q <= S_SERVE;
      endcase
    end
  end

  assign state = state_q;

  function automatic logic [7:0] ball_rom(input logic [2:0] row);
    case (row)
      3'd0, 3'd7: ball_rom = 8'b0011_1100;
      3'd1, 3'd6: ball_rom = 8'b0111_1110;
      default:    ball_rom = 8'b1111_1111;
    endcase
  endfunction

  logic       pad_l_on, pad_r_on, ball_box, ball_on, line_on;
  logic [2:0] rom_row, rom_col;
  logic [7:0] rom_bits;

  always_comb begin
    pad_l_on = (x >= PL_X0) && (x <= PL_X1) && (y >= pad_l) && (y <= pad_l + PAD_HM1);
    pad_r_on = (x >= PR_X0) && (x <= PR_X1) && (y >= pad_r) && (y <= pad_r + PAD_HM1);
    ball_box = (x >= ball_x) && (x <= ball_r) && (y >= ball_y) && (y <= ball_b);
    rom_row  = 3'(y - ball_y);
    rom_col  = 3'(x - ball_x);
    rom_bits = ball_rom(rom_row);
    ball_on  = ball_box && rom_bits[rom_col];
    line_on  = ((x == LINE_X0) || (x == LINE_X1)) && !y[4];

    if (!video_on)
      rgb = 12'h000;
    else if (pad_l_on || pad_r_on)
      rgb = PAD_RGB;
    else if (ball_on)
      rgb = BALL_RGB;
    else if (line_on)
      rgb = LINE_RGB;
    else
      rgb = BG_RGB;
  end

endmodule

// File: tb/tb_pong_game_2p.sv
// Directed bench for pong_game_2p: frame ticks are forced by driving x/y directly,
// expected values go into a scoreboard queue that a negedge monitor drains.
module tb_pong_game_2p;
  localparam logic [11:0] PAD  = 12'hAAA;
  localparam logic [11:0] BALL = 12'hFFF;
  localparam logic [11:0] LINE = 12'h777;
  localparam logic [11:0] BG   = 12'h111;

  localparam int K_RGB = 0, K_STATE = 1, K_SL = 2, K_SR = 3, K_GO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        up_l, down_l, up_r, down_r, serve, video_on;
  logic [9:0]  x, y;
  logic [11:0] rgb;
  logic [3:0]  score_l, score_r;
  logic [1:0]  state;
  logic        game_over;

  always #5 clk = ~clk;

  pong_game_2p dut (
    .clk(clk), .reset(reset),
    .up_l(up_l), .down_l(down_l), .up_r(up_r), .down_r(down_r),
    .serve(serve), .video_on(video_on), .x(x), .y(y),
    .rgb(rgb), .score_l(score_l), .score_r(score_r),
    .state(state), .game_over(game_over)
  );

  typedef struct {
    int          kind;
    logic [11:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  logic        probe_valid = 1'b0;
  logic [11:0] act;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (probe_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: probe with no expected entry");
      end else begin
        cur = sb.pop_front();
        case (cur.kind)
          K_RGB:   act = rgb;
          K_STATE: act = {10'd0, state};
          K_SL:    act = {8'd0, score_l};
          K_SR:    act = {8'd0, score_r};
          K_GO:    act = {11'd0, game_over};
          default: act = 12'hxxx;
        endcase
        if (act !== cur.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input int kind, input logic [11:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
    probe_valid = 1'b1;
    @(posedge clk);
    #1 probe_valid = 1'b0;
  endtask

  task automatic pix(input int px, input int py, input logic vo, input logic [11:0] exp,
                     input string name);
    x = 10'(px);
    y = 10'(py);
    video_on = vo;
    issue(K_RGB, exp, name);
    x = 10'd0;
    y = 10'd0;
    video_on = 1'b1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      x = 10'd0;
      y = 10'd481;
      @(posedge clk);
      #1 y = 10'd0;
    end
  endtask

  task automatic serve_tick();
    serve = 1'b0;
    tick_n(1);
    serve = 1'b1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    up_l = 1'b1; down_l = 1'b1; up_r = 1'b1; down_r = 1'b1;
    serve = 1'b1; video_on = 1'b1; x = 10'd0; y = 10'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    issue(K_STATE, 12'd0, "reset_state");
    issue(K_SL, 12'd0, "reset_score_l");
    issue(K_SR, 12'd0, "reset_score_r");
    issue(K_GO, 12'd0, "reset_game_over");
    pix(319, 236, 1'b1, BALL, "ball_centre");
    pix(316, 236, 1'b1, BG, "ball_rom_corner");
    pix(33, 204, 1'b1, PAD, "pad_l_top");
    pix(33, 203, 1'b1, BG, "above_pad_l");
    pix(605, 275, 1'b1, PAD, "pad_r_bottom");
    pix(605, 276, 1'b1, BG, "below_pad_r");
    pix(320, 5, 1'b1, LINE, "centre_line");
    pix(320, 5, 1'b0, 12'h000, "blanking");
    pix(320, 16, 1'b1, BG, "centre_line_gap");

    // serve held low off-tick is ignored
    serve = 1'b0;
    repeat (3) @(posedge clk);
    #1 serve = 1'b1;
    issue(K_STATE, 12'd0, "serve_off_tick_ignored");

    serve_tick();
    issue(K_STATE, 12'd1, "serve_to_play");
    pix(319, 236, 1'b1, BALL, "ball_still_on_serve_tick");
    tick_n(1);
    pix(321, 238, 1'b1, BALL, "ball_first_move");
    pix(318, 238, 1'b1, BG, "ball_first_move_corner");
    tick_n(117);
    pix(555, 468, 1'b1, BALL, "bottom_wall_bounce");
    tick_n(40);
    issue(K_STATE, 12'd1, "play_before_miss");
    issue(K_SL, 12'd0, "score_l_before_miss");
    pix(635, 388, 1'b1, BALL, "ball_at_right_edge");
    tick_n(1);
    issue(K_STATE, 12'd2, "right_miss_to_pause");
    issue(K_SL, 12'd1, "right_miss_score_l");
    issue(K_SR, 12'd0, "right_miss_score_r");
    pix(635, 388, 1'b1, BALL, "ball_frozen_in_pause");
    tick_n(59);
    issue(K_STATE, 12'd2, "pause_last_frame");
    tick_n(1);
    issue(K_STATE, 12'd0, "pause_to_serve");
    pix(319, 236, 1'b1, BALL, "ball_recentred");

    // left paddle limits while parked in SERVE
    up_l = 1'b0;
    tick_n(1);
    pix(33, 201, 1'b1, PAD, "pad_l_up_one");
    pix(33, 200, 1'b1, BG, "pad_l_up_one_above");
    tick_n(67);
    pix(33, 0, 1'b1, PAD, "pad_l_at_top");
    pix(33, 72, 1'b1, BG, "pad_l_at_top_below");
    tick_n(1);
    pix(33, 0, 1'b1, PAD, "pad_l_top_clamp");
    pix(33, 71, 1'b1, PAD, "pad_l_top_clamp_bottom");
    down_l = 1'b0;
    tick_n(3);
    pix(33, 0, 1'b1, PAD, "pad_l_both_hold");
    pix(33, 72, 1'b1, BG, "pad_l_both_hold_below");
    up_l = 1'b1;
    tick_n(136);
    pix(33, 408, 1'b1, PAD, "pad_l_at_bottom");
    pix(33, 407, 1'b1, BG, "pad_l_at_bottom_above");
    tick_n(2);
    pix(33, 479, 1'b1, PAD, "pad_l_bottom_clamp");
    pix(33, 407, 1'b1, BG, "pad_l_bottom_clamp_above");
    down_l = 1'b1;
    pix(605, 204, 1'b1, PAD, "pad_r_untouched");

    // same trajectory repeats: left wins points 2..7
    for (int p = 2; p <= 7; p++) begin
      serve_tick();
      tick_n(159);
      issue(K_SL, 12'(p), "score_l_point");
      issue(K_STATE, 12'd2, "point_pause");
      tick_n(60);
      issue(K_STATE, (p == 7) ? 12'd3 : 12'd0, "after_point_pause");
    end
    issue(K_GO, 12'd1, "game_over_set");
    issue(K_SR, 12'd0, "score_r_at_over");

    up_l = 1'b0;
    tick_n(1);
    up_l = 1'b1;
    pix(33, 408, 1'b1, PAD, "pad_frozen_in_over");
    pix(33, 405, 1'b1, BG, "pad_frozen_in_over_above");
    issue(K_STATE, 12'd3, "over_holds_without_serve");
    serve_tick();
    issue(K_STATE, 12'd0, "over_to_serve");
    issue(K_SL, 12'd0, "over_clears_score_l");
    issue(K_GO, 12'd0, "over_clears_game_over");
    pix(319, 236, 1'b1, BALL, "over_recentres_ball");

    // asynchronous reset in the middle of play
    serve_tick();
    tick_n(10);
    reset = 1'b0;
    issue(K_STATE, 12'd0, "async_reset_state");
    pix(319, 236, 1'b1, BALL, "async_reset_ball");
    pix(33, 204, 1'b1, PAD, "async_reset_pad_l");
    reset = 1'b1;

    // right paddle bounce, top wall bounce, left paddle bounce
    serve_tick();
    up_l = 1'b0;
    down_r = 1'b0;
    tick_n(21);
    up_l = 1'b1;
    tick_n(47);
    down_r = 1'b1;
    pix(605, 408, 1'b1, PAD, "pad_r_moved_down");
    pix(605, 407, 1'b1, BG, "pad_r_moved_down_above");
    pix(33, 141, 1'b1, PAD, "pad_l_moved_up");
    pix(33, 140, 1'b1, BG, "pad_l_moved_up_above");
    tick_n(73);
    pix(597, 422, 1'b1, BALL, "right_paddle_bounce");
    issue(K_SL, 12'd0, "right_bounce_no_score");
    tick_n(211);
    pix(175, 11, 1'b1, BALL, "top_wall_bounce");
    tick_n(69);
    pix(41, 142, 1'b1, BALL, "left_paddle_bounce");
    issue(K_SR, 12'd0, "left_bounce_no_score");
    issue(K_STATE, 12'd1, "left_bounce_still_play");

    // left miss: right scores, next serve heads left
    pulse_reset();
    serve_tick();
    down_r = 1'b0;
    tick_n(68);
    down_r = 1'b1;
    tick_n(370);
    issue(K_STATE, 12'd1, "play_before_left_miss");
    issue(K_SR, 12'd0, "score_r_before_left_miss");
    tick_n(1);
    issue(K_SR, 12'd1, "left_miss_score_r");
    issue(K_STATE, 12'd2, "left_miss_to_pause");
    issue(K_SL, 12'd0, "left_miss_score_l");
    pix(3, 176, 1'b1, BALL, "ball_at_left_edge");
    tick_n(60);
    issue(K_STATE, 12'd0, "left_miss_pause_done");
    serve_tick();
    tick_n(1);
    pix(317, 238, 1'b1, BALL, "serve_toward_left");
    pix(321, 238, 1'b1, BG, "serve_toward_left_edge");

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
